muldiv_unit: RTL and testbench
==============================

# muldiv_unit

Parametrised multi-cycle multiply/divide unit with HI/LO result registers, issued alongside the single-cycle ALU. Computes signed/unsigned WIDTH×WIDTH products and WIDTH/WIDTH quotient+remainder iteratively (one bit per cycle). Holds `busy` so the control path can stall the PC unit via `skipCycle`, and pulses `done` when HI/LO are valid.

## Interface
- `WIDTH`, 32: operand and HI/LO width; must be ≥ 4.
- `clk`  in  1  clock, all state updates on posedge.
- `reset`  in  1  synchronous, active-high; one clock, reset is synchronous and active-high.
- `start`  in  1  issue request; sampled only when `busy`=0.
- `op`  in  3  operation code (see package).
- `a`, `b`  in  WIDTH each  operands (multiplicand/dividend, multiplier/divisor); sampled with `start`.
- `abort`  in  1  cancel an in-flight operation.
- `busy`  out  1  operation in flight; reset 0.
- `done`  out  1  one-cycle pulse, HI/LO freshly valid; reset 0.
- `div_by_zero`  out  1  valid only with `done`; reset 0.
- `hi`, `lo`  out  WIDTH each  result registers; reset 0.

## Operation
- FSM states: IDLE, RUN, FIX.
- IDLE: `start`=1 with MULTU/MULT/DIVU/DIV latches operand magnitudes and sign info, clears the iteration counter, goes to RUN. MTHI writes `a` to `hi`, MTLO writes `a` to `lo`, both at the same edge; no `busy`, no `done`. Any other op is ignored.
- RUN: WIDTH iterations, one per cycle. Multiply uses shift-add over a 2·WIDTH accumulator. Divide uses restoring shift-subtract, with a WIDTH+1-bit partial remainder. Counter width is clog2(WIDTH)+1.
- FIX: one cycle. Applies sign correction and writes `hi`/`lo`, then goes to IDLE.
  - MULT: the product is negated when a[W-1]^b[W-1].
  - DIV: the quotient is negated when a[W-1]^b[W-1]; the remainder takes the sign of `a`.
  - MULT/MULTU: `hi` = upper half, `lo` = lower half.
  - DIV/DIVU: `lo` = quotient, `hi` = remainder.
- Divide by zero:
  - `lo` = all ones, `hi` = `a` (unmodified dividend), `div_by_zero`=1 with `done`. This applies to both DIV and DIVU.
- Signed overflow (DIV of MIN by −1): `lo` = MIN, `hi` = 0. No flag.
- `start` while `busy`=1 is ignored. No queuing.
- `abort` in RUN or FIX returns to IDLE next edge. `hi`/`lo` are unchanged and there is no `done`. `abort` in IDLE has no effect; if `start` is also high, `start` wins.
- `reset` overrides everything, including mid-operation: state IDLE, all outputs 0.

## Timing
- `start` sampled at edge E0. `busy`=1 from the cycle after E0 through FIX, i.e. WIDTH+1 cycles.
- `hi`/`lo` are updated at the edge ending FIX, which is E0+WIDTH+1.
- `done`=1 and `busy`=0 in the following cycle. Start-to-done latency is WIDTH+2 cycles (34 at WIDTH=32).
- Back-to-back: `start` is accepted in the `done` cycle, since `busy`=0.
- Control must stall reads of `hi`/`lo` while `busy`=1. Values read during `busy` are the previous results.
- MTHI/MTLO take effect at the next edge, for a read latency of 1.

## Structure
- `muldiv_pkg` holds:
  - op codes: MD_MULTU=0, MD_MULT=1, MD_DIVU=2, MD_DIV=3, MD_MTHI=4, MD_MTLO=5 (6–7 are no-ops);
  - FSM state encoding;
  - a `muldiv_neg` helper, two's-complement negate with parametrised width.
- Single module. No sub-module is needed: multiply and divide share the 2·WIDTH shift register and the counter.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → `hi`=0xFFFFFFFE, `lo`=0x00000001. `done` exactly 34 cycles after the `start` edge, with `busy` high for 33 cycles.
- MULT −3 × 5 → `hi`=0xFFFFFFFF, `lo`=0xFFFFFFF1. DIV −7 / 2 → `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF. DIVU 100 / 7 → `lo`=14, `hi`=2.
- DIVU 5 / 0 → `lo`=0xFFFFFFFF, `hi`=5, `div_by_zero`=1 with `done`. DIV 0x80000000 / 0xFFFFFFFF → `lo`=0x80000000, `hi`=0, `div_by_zero`=0.
- Second `start` (MULTU 2×2) at cycle 10 of an op is ignored. A `start` in the `done` cycle is accepted, and the next `done` arrives 34 cycles later.
- `abort` at cycle 5 of DIVU, after an MTHI 0x1234 / MTLO 0x5678 preload → `hi`/`lo` stay 0x1234/0x5678, no `done`, `busy`=0 next cycle.
- `reset` at cycle 20 of MULT → the next cycle has `busy`=0, `done`=0, `hi`=`lo`=0. A fresh MULTU 3×4 then completes with `lo`=12.
- Also run at WIDTH=8: MULT 0x80 × 0x80 → `hi`=0x40, `lo`=0x00 in 10 cycles.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op codes,
// FSM state encoding and a wide two's-complement negate helper.
package muldiv_pkg;

  localparam logic [2:0] MD_MULTU = 3'd0;
  localparam logic [2:0] MD_MULT  = 3'd1;
  localparam logic [2:0] MD_DIVU  = 3'd2;
  localparam logic [2:0] MD_DIV   = 3'd3;
  localparam logic [2:0] MD_MTHI  = 3'd4;
  localparam logic [2:0] MD_MTLO  = 3'd5;

  // Widest value muldiv_neg handles; covers 2*WIDTH for WIDTH up to 64.
  localparam int unsigned MD_MAXW = 128;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_RUN  = 2'd1,
    MD_FIX  = 2'd2
  } md_state_e;

  // Callers size-cast the result back to their own width; the low bits of a
  // two's-complement negate do not depend on the upper bits.
  function automatic logic [MD_MAXW-1:0] muldiv_neg(input logic [MD_MAXW-1:0] x);
    return ~x + MD_MAXW'(1);
  endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Multi-cycle signed/unsigned multiply and divide with HI/LO result registers.
// One bit per cycle; multiply and divide share the 2*WIDTH shift register.
module muldiv_unit import muldiv_pkg::*; #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;
  localparam int unsigned W2 = 2 * WIDTH;

  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] x);
    return WIDTH'(muldiv_neg(MD_MAXW'(x)));
  endfunction

  function automatic logic [W2-1:0] neg_w2(input logic [W2-1:0] x);
    return W2'(muldiv_neg(MD_MAXW'(x)));
  endfunction

  md_state_e        state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [W2-1:0]    acc_q, acc_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic             is_div_q, is_div_d;
  logic             qneg_q, qneg_d;
  logic             rneg_q, rneg_d;
  logic             dz_q, dz_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             done_q, done_d;
  logic             dbz_q, dbz_d;

  logic             sgn, a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag, quo, rem;
  logic [WIDTH:0]   madd, sh, diff;
  logic [W2-1:0]    prod;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    is_div_d = is_div_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    dz_d     = dz_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    dbz_d    = 1'b0;

    sgn   = (op == MD_MULT) || (op == MD_DIV);
    a_neg = sgn & a[WIDTH-1];
    b_neg = sgn & b[WIDTH-1];
    a_mag = a_neg ? neg_w(a) : a;
    b_mag = b_neg ? neg_w(b) : b;

    madd = {1'b0, acc_q[W2-1:WIDTH]} + {1'b0, mcand_q};
    sh   = acc_q[W2-1:WIDTH-1];
    diff = sh - {1'b0, mcand_q};
    prod = qneg_q ? neg_w2(acc_q) : acc_q;
    quo  = qneg_q ? neg_w(acc_q[WIDTH-1:0]) : acc_q[WIDTH-1:0];
    rem  = rneg_q ? neg_w(acc_q[W2-1:WIDTH]) : acc_q[W2-1:WIDTH];

    case (state_q)
      MD_IDLE: begin
        if (start) begin
          case (op)
            MD_MULTU, MD_MULT, MD_DIVU, MD_DIV: begin
              state_d  = MD_RUN;
              cnt_d    = '0;
              is_div_d = op[1];
              qneg_d   = a_neg ^ b_neg;
              rneg_d   = a_neg;
              dz_d     = (b == '0);
              acc_d    = {{WIDTH{1'b0}}, (op[1] ? a_mag : b_mag)};
              mcand_d  = op[1] ? b_mag : a_mag;
            end
            MD_MTHI: hi_d = a;
            MD_MTLO: lo_d = a;
            default: ;
          endcase
        end
      end
      MD_RUN: begin
        if (abort) begin
          state_d = MD_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (is_div_q) begin
            if (!diff[WIDTH]) acc_d = {diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
            else              acc_d = {sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
          end else begin
            acc_d = acc_q[0] ? {madd, acc_q[WIDTH-1:1]} : {1'b0, acc_q[W2-1:1]};
          end
          if (cnt_q == CW'(WIDTH - 1)) state_d = MD_FIX;
        end
      end
      MD_FIX: begin
        state_d = MD_IDLE;
        if (!abort) begin
          done_d = 1'b1;
          if (is_div_q) begin
            // A zero divisor leaves |a| in the remainder half, so the normal
            // sign fix-up already reproduces the original dividend for hi.
            lo_d  = dz_q ? '1 : quo;
            hi_d  = rem;
            dbz_d = dz_q;
          end else begin
            hi_d = prod[W2-1:WIDTH];
            lo_d = prod[WIDTH-1:0];
          end
        end
      end
      default: state_d = MD_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= MD_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      is_div_q <= 1'b0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      dz_q     <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      is_div_q <= is_div_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
      dz_q     <= dz_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
      dbz_q    <= dbz_d;
    end
  end

  assign busy        = (state_q != MD_IDLE);
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed vector table, corner-case
// sequences (ignored start, abort, mid-op reset) and randomized ops vs a model.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, start, abort;
  logic [2:0]  op;
  logic [31:0] a, b, hi, lo;
  logic        busy, done, dbz;

  logic        st8;
  logic [2:0]  op8;
  logic [7:0]  a8, b8, hi8, lo8;
  logic        busy8, done8, dbz8;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .abort(abort), .busy(busy), .done(done), .div_by_zero(dbz),
    .hi(hi), .lo(lo)
  );

  muldiv_unit #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .start(st8), .op(op8), .a(a8), .b(b8),
    .abort(1'b0), .busy(busy8), .done(done8), .div_by_zero(dbz8),
    .hi(hi8), .lo(lo8)
  );

  int unsigned pass_cnt = 0;
  int unsigned chk_cnt  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference: plain integer arithmetic on the architectural definitions.
  function automatic void ref_md(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                                 output logic [31:0] rh, output logic [31:0] rl, output logic rz);
    longint sx, sy, sp;
    logic [63:0] p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    rz = 1'b0;
    rh = '0;
    rl = '0;
    case (o)
      MD_MULTU: begin p = {32'd0, x} * {32'd0, y}; rh = p[63:32]; rl = p[31:0]; end
      MD_MULT:  begin sp = sx * sy; p = sp; rh = p[63:32]; rl = p[31:0]; end
      default: begin
        if (y == 32'd0) begin
          rl = 32'hFFFF_FFFF; rh = x; rz = 1'b1;
        end else if (o == MD_DIV && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
          rl = 32'h8000_0000; rh = 32'd0;
        end else if (o == MD_DIVU) begin
          rl = x / y; rh = x % y;
        end else begin
          rl = 32'(sx / sy); rh = 32'(sx % sy);
        end
      end
    endcase
  endfunction

  // Called right after an edge; start is sampled at the next edge (E0).
  task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    op = o; a = x; b = y; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // lat counts edges from E0 through the edge after which done is seen.
  // inj >= 0 drives a MULTU 2x2 start after that many post-E0 edges.
  task automatic wait_done(input int inj, output int lat, output int bsy);
    int n;
    bsy = busy ? 1 : 0;
    lat = 0;
    for (n = 1; n <= 200; n++) begin
      @(posedge clk); #1;
      if (done) break;
      if (busy) bsy++;
      if (n == inj) begin op = MD_MULTU; a = 32'd2; b = 32'd2; start = 1'b1; end
      else start = 1'b0;
    end
    start = 1'b0;
    if (!done) chk("done_timeout", 64'd0, 64'd1);
    lat = n + 1;
  endtask

  task automatic run8(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y, output int lat);
    int n;
    op8 = o; a8 = x; b8 = y; st8 = 1'b1;
    @(posedge clk); #1;
    st8 = 1'b0;
    for (n = 1; n <= 50; n++) begin
      @(posedge clk); #1;
      if (done8) break;
    end
    if (!done8) chk("w8_done_timeout", 64'd0, 64'd1);
    lat = n + 1;
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a, b, hi, lo;
    logic        dbz;
  } vec_t;

  vec_t vecs[9];

  initial begin
    int lat, bsy, done_seen;
    logic [31:0] eh, el;
    logic        ez;
    logic [2:0]  rop;
    logic [31:0] ra, rb;

    vecs[0] = '{MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
    vecs[1] = '{MD_MULT,  32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0};
    vecs[2] = '{MD_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
    vecs[3] = '{MD_DIVU,  32'd100,       32'd7,         32'd2,         32'd14,        1'b0};
    vecs[4] = '{MD_DIVU,  32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF, 1'b1};
    vecs[5] = '{MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 1'b0};
    vecs[6] = '{MD_DIV,   32'hFFFF_FFF7, 32'd0,         32'hFFFF_FFF7, 32'hFFFF_FFFF, 1'b1};
    vecs[7] = '{MD_DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 1'b0};
    vecs[8] = '{MD_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0,         1'b0};

    reset = 1'b1; start = 1'b0; abort = 1'b0; op = '0; a = '0; b = '0;
    st8 = 1'b0; op8 = '0; a8 = '0; b8 = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_dbz",  64'(dbz),  64'd0);
    chk("reset_hi",   64'(hi),   64'd0);
    chk("reset_lo",   64'(lo),   64'd0);

    // Each next issue happens in the done cycle, so back-to-back is covered.
    for (int i = 0; i < 9; i++) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b);
      wait_done(-1, lat, bsy);
      chk($sformatf("vec%0d_latency", i), 64'(lat), 64'd34);
      chk($sformatf("vec%0d_busy_cycles", i), 64'(bsy), 64'd33);
      chk($sformatf("vec%0d_hi", i), 64'(hi), 64'(vecs[i].hi));
      chk($sformatf("vec%0d_lo", i), 64'(lo), 64'(vecs[i].lo));
      chk($sformatf("vec%0d_dbz", i), 64'(dbz), 64'(vecs[i].dbz));
    end

    // Start while busy is ignored.
    issue(MD_MULTU, 32'd7, 32'd9);
    wait_done(9, lat, bsy);
    chk("ignored_start_latency", 64'(lat), 64'd34);
    chk("ignored_start_lo", 64'(lo), 64'd63);
    chk("ignored_start_hi", 64'(hi), 64'd0);
    @(posedge clk); #1;
    chk("ignored_start_not_queued", 64'(busy), 64'd0);

    // MTHI/MTLO preload then abort mid-divide.
    issue(MD_MTHI, 32'h1234, 32'd0);
    chk("mthi_hi", 64'(hi), 64'h1234);
    chk("mthi_busy", 64'(busy), 64'd0);
    issue(MD_MTLO, 32'h5678, 32'd0);
    chk("mtlo_lo", 64'(lo), 64'h5678);
    chk("mtlo_done", 64'(done), 64'd0);
    issue(MD_DIVU, 32'd100, 32'd7);
    repeat (4) begin @(posedge clk); #1; end
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    done_seen = 0;
    repeat (40) begin @(posedge clk); #1; if (done) done_seen++; end
    chk("abort_no_done", 64'(done_seen), 64'd0);
    chk("abort_hi", 64'(hi), 64'h1234);
    chk("abort_lo", 64'(lo), 64'h5678);

    // Reset in the middle of a multiply.
    issue(MD_MULT, 32'd123, 32'hFFFF_FFD3);
    repeat (19) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("midreset_busy", 64'(busy), 64'd0);
    chk("midreset_done", 64'(done), 64'd0);
    chk("midreset_hi", 64'(hi), 64'd0);
    chk("midreset_lo", 64'(lo), 64'd0);
    issue(MD_MULTU, 32'd3, 32'd4);
    wait_done(-1, lat, bsy);
    chk("postreset_latency", 64'(lat), 64'd34);
    chk("postreset_lo", 64'(lo), 64'd12);
    chk("postreset_hi", 64'(hi), 64'd0);

    // Randomized operations against the reference model.
    for (int i = 0; i < 40; i++) begin
      rop = 3'($urandom_range(0, 3));
      ra  = $urandom;
      case ($urandom_range(0, 4))
        0:       rb = 32'd0;
        1:       rb = 32'($urandom_range(1, 15));
        2:       rb = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
        default: rb = $urandom;
      endcase
      if ($urandom_range(0, 9) == 0) ra = 32'h8000_0000;
      ref_md(rop, ra, rb, eh, el, ez);
      issue(rop, ra, rb);
      wait_done(-1, lat, bsy);
      chk($sformatf("rnd%0d_op%0d_%h_%h_hi", i, rop, ra, rb), 64'(hi), 64'(eh));
      chk($sformatf("rnd%0d_op%0d_%h_%h_lo", i, rop, ra, rb), 64'(lo), 64'(el));
      chk($sformatf("rnd%0d_dbz", i), 64'(dbz), 64'(ez));
    end

    // Narrow instance.
    run8(MD_MULT, 8'h80, 8'h80, lat);
    chk("w8_mult_latency", 64'(lat), 64'd10);
    chk("w8_mult_hi", 64'(hi8), 64'h40);
    chk("w8_mult_lo", 64'(lo8), 64'h00);
    run8(MD_DIV, 8'hF9, 8'h02, lat);
    chk("w8_div_lo", 64'(lo8), 64'hFD);
    chk("w8_div_hi", 64'(hi8), 64'hFF);
    run8(MD_DIVU, 8'h2A, 8'h00, lat);
    chk("w8_dz_lo", 64'(lo8), 64'hFF);
    chk("w8_dz_hi", 64'(hi8), 64'h2A);
    chk("w8_dz_flag", 64'(dbz8), 64'd1);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
